// File: rtl/axi4_single_beat_master.sv
// -----------------------------------------------------------------------------
// axi4_single_beat_master
//
// AXI4 initiator that turns one command from a simple valid/ready port into a
// single-beat AXI4 read or write (LEN = 0, INCR, full-width SIZE). It returns
// the AXI response on a valid/ready response port. Only one transaction is
// outstanding at a time. It is used by the debug/boot controller and as a
// driver for slave peripherals.
//
// Ports
//   clk_i, reset_i      clock (rising edge), asynchronous active-low reset
//   cmd_*               command port: we/addr/wdata/wstrb with valid/ready
//   rsp_*               response port: rdata/resp/proto_err with valid/ready
//   m_aw* / m_w* / m_b* AXI4 write address, write data, write response
//   m_ar* / m_r*        AXI4 read address, read data
//
// Timing with a zero-wait slave: the command is accepted at cycle 0, AW/W (or
// AR) handshake at cycle 1, B (or R) at cycle 2, rsp_valid_o at cycle 3.
// -----------------------------------------------------------------------------
module axi4_single_beat_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int TXN_ID = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    // Command port
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_W-1:0]     cmd_addr_i,
    input  logic [DATA_W-1:0]     cmd_wdata_i,
    input  logic [DATA_W/8-1:0]   cmd_wstrb_i,

    // Response port
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic [1:0]            rsp_resp_o,
    output logic                  rsp_proto_err_o,

    // AXI4 write address channel
    output logic [ID_W-1:0]       m_awid_o,
    output logic [ADDR_W-1:0]     m_awaddr_o,
    output logic [7:0]            m_awlen_o,
    output logic [2:0]            m_awsize_o,
    output logic [1:0]            m_awburst_o,
    output logic                  m_awvalid_o,
    input  logic                  m_awready_i,

    // AXI4 write data channel
    output logic [DATA_W-1:0]     m_wdata_o,
    output logic [DATA_W/8-1:0]   m_wstrb_o,
    output logic                  m_wlast_o,
    output logic                  m_wvalid_o,
    input  logic                  m_wready_i,

    // AXI4 write response channel
    input  logic [ID_W-1:0]       m_bid_i,
    input  logic [1:0]            m_bresp_i,
    input  logic                  m_bvalid_i,
    output logic                  m_bready_o,

    // AXI4 read address channel
    output logic [ID_W-1:0]       m_arid_o,
    output logic [ADDR_W-1:0]     m_araddr_o,
    output logic [7:0]            m_arlen_o,
    output logic [2:0]            m_arsize_o,
    output logic [1:0]            m_arburst_o,
    output logic                  m_arvalid_o,
    input  logic                  m_arready_i,

    // AXI4 read data channel
    input  logic [ID_W-1:0]       m_rid_i,
    input  logic [DATA_W-1:0]     m_rdata_i,
    input  logic [1:0]            m_rresp_i,
    input  logic                  m_rlast_i,
    input  logic                  m_rvalid_i,
    output logic                  m_rready_o
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int              STRB_W     = DATA_W / 8;
    localparam logic [2:0]      AXI_SIZE   = 3'($clog2(STRB_W));
    localparam logic [1:0]      AXI_INCR   = 2'b01;
    localparam logic [ID_W-1:0] TXN_ID_VAL = ID_W'(TXN_ID);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_RSP
    } state_e;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_e                state_q;
    logic                  cmd_ready_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  aw_done_q;
    logic                  w_done_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;

    logic                  rsp_valid_q;
    logic [DATA_W-1:0]     rsp_rdata_q;
    logic [1:0]            rsp_resp_q;
    logic                  rsp_err_q;

    // -------------------------------------------------------------------------
    // Handshakes and derived next-state terms
    // -------------------------------------------------------------------------
    logic cmd_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic rsp_hs;
    logic aw_done_d;
    logic w_done_d;
    logic b_err_d;
    logic r_err_d;

    assign cmd_hs = cmd_valid_i & cmd_ready_q;
    assign aw_hs  = awvalid_q & m_awready_i;
    assign w_hs   = wvalid_q  & m_wready_i;
    // bready/rready are only ever high in their own state, so B/R beats that
    // arrive elsewhere are never accepted.
    assign b_hs   = bready_q  & m_bvalid_i;
    assign ar_hs  = arvalid_q & m_arready_i;
    assign r_hs   = rready_q  & m_rvalid_i;
    assign rsp_hs = rsp_valid_q & rsp_ready_i;

    // A channel counts as done if it finished earlier or finishes this cycle,
    // so AW and W may complete together or in either order.
    assign aw_done_d = aw_done_q | aw_hs;
    assign w_done_d  = w_done_q  | w_hs;

    assign b_err_d = (m_bid_i != TXN_ID_VAL);
    assign r_err_d = (m_rid_i != TXN_ID_VAL) | ~m_rlast_i;

    // -------------------------------------------------------------------------
    // Main FSM
    // -------------------------------------------------------------------------
    // NOTE: every register in this block uses non-blocking assignment so all
    // state updates at the edge see the same pre-edge values; blocking
    // assignment here would make results depend on statement order.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Also raises ready on the first cycle after reset release.
                    cmd_ready_q <= 1'b1;
                    if (cmd_hs) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr_i;
                        wdata_q     <= cmd_wdata_i;
                        wstrb_q     <= cmd_wstrb_i;
                        if (cmd_we_i) begin
                            state_q   <= S_WR_REQ;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end else begin
                            state_q   <= S_RD_REQ;
                            arvalid_q <= 1'b1;
                        end
                    end
                end

                S_WR_REQ: begin
                    // Each valid drops only after its own handshake, and the
                    // address/data registers are held, so AXI stability holds.
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_done_d && w_done_d) begin
                        state_q   <= S_WR_RESP;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                    end
                end

                S_WR_RESP: begin
                    if (b_hs) begin
                        state_q     <= S_RSP;
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= m_bresp_i;
                        rsp_err_q   <= b_err_d;
                    end
                end

                S_RD_REQ: begin
                    if (ar_hs) begin
                        state_q   <= S_RD_DATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end

                S_RD_DATA: begin
                    if (r_hs) begin
                        state_q     <= S_RSP;
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= m_rdata_i;
                        rsp_resp_q  <= m_rresp_i;
                        rsp_err_q   <= r_err_d;
                    end
                end

                S_RSP: begin
                    // Response fields stay frozen until the consumer accepts;
                    // the AXI side is idle for as long as that takes.
                    if (rsp_hs) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign cmd_ready_o     = cmd_ready_q;

    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_resp_o      = rsp_resp_q;
    assign rsp_proto_err_o = rsp_err_q;

    assign m_awid_o        = TXN_ID_VAL;
    assign m_awaddr_o      = addr_q;
    assign m_awlen_o       = 8'd0;
    assign m_awsize_o      = AXI_SIZE;
    assign m_awburst_o     = AXI_INCR;
    assign m_awvalid_o     = awvalid_q;

    assign m_wdata_o       = wdata_q;
    assign m_wstrb_o       = wstrb_q;
    assign m_wlast_o       = 1'b1;
    assign m_wvalid_o      = wvalid_q;

    assign m_bready_o      = bready_q;

    assign m_arid_o        = TXN_ID_VAL;
    assign m_araddr_o      = addr_q;
    assign m_arlen_o       = 8'd0;
    assign m_arsize_o      = AXI_SIZE;
    assign m_arburst_o     = AXI_INCR;
    assign m_arvalid_o     = arvalid_q;

    assign m_rready_o      = rready_q;

endmodule

// File: doc/axi4_single_beat_master.md
Name: axi4_single_beat_master

Overview:
- AXI4 initiator (master) that issues one single-beat read or write per request from a simple valid/ready command port.
- Returns the AXI response and read data on a valid/ready response port.
- Counterpart to the SoC peripheral AXI4 slave subsystem. Used by the debug/boot controller and as the verification driver for slave peripherals.
- One transaction outstanding at a time; no bursts.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width (power of two, >= 8).
- ID_W, 4, AXI ID width.
- TXN_ID, 0, ID driven on AWID/ARID and expected on BID/RID.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- reset_i  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_W  byte address.
- cmd_wdata_i  in  DATA_W  write data.
- cmd_wstrb_i  in  DATA_W/8  write strobes (ignored on reads).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_rdata_o  out  DATA_W  read data (0 for writes).
- rsp_resp_o  out  2  captured BRESP/RRESP.
- rsp_proto_err_o  out  1  ID mismatch, or RLAST=0 on a read.
- m_awid_o/m_awaddr_o/m_awlen_o(8)/m_awsize_o(3)/m_awburst_o(2)/m_awvalid_o  out; m_awready_i  in.
- m_wdata_o/m_wstrb_o/m_wlast_o/m_wvalid_o  out; m_wready_i  in.
- m_bid_i(ID_W)/m_bresp_i(2)/m_bvalid_i  in; m_bready_o  out.
- m_arid_o/m_araddr_o/m_arlen_o(8)/m_arsize_o(3)/m_arburst_o(2)/m_arvalid_o  out; m_arready_i  in.
- m_rid_i/m_rdata_i/m_rresp_i(2)/m_rlast_i/m_rvalid_i  in; m_rready_o  out.

Behaviour:
- Fixed fields: AWLEN = ARLEN = 0; AWSIZE = ARSIZE = log2(DATA_W/8); AWBURST = ARBURST = 2'b01; WLAST = 1; AWID = ARID = TXN_ID.
- State machine: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- Reset (reset_i = 0, asynchronous):
  - State goes to IDLE; all *valid_o, m_bready_o, m_rready_o and rsp_* are 0.
  - cmd_ready_o is 0 while reset is asserted.
  - Address/data registers are 0.
  - Reset mid-transaction abandons it immediately; no response is produced.
- IDLE: cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o, register addr/wdata/wstrb.
  - cmd_we_i = 1 -> WR_REQ, with m_awvalid_o = m_wvalid_o = 1 from the next cycle.
  - cmd_we_i = 0 -> RD_REQ, with m_arvalid_o = 1 from the next cycle.
- cmd_ready_o = 0 in every state other than IDLE.
- WR_REQ: AW and W channels complete independently.
  - Each valid drops the cycle after its own valid & ready handshake.
  - Per-channel done flags are kept.
  - AW and W may complete in the same cycle or in either order.
  - Move to WR_RESP once both flags are set, or set in the current cycle.
- Valid stability: AWADDR/WDATA/WSTRB/ARADDR do not change while the corresponding valid is high. A valid never drops without a handshake.
- WR_RESP: m_bready_o = 1.
  - On m_bvalid_i, capture BRESP.
  - proto_err = (BID != TXN_ID); rdata = 0.
  - Go to RSP.
- RD_REQ: hold m_arvalid_o until m_arready_i, then go to RD_DATA.
- RD_DATA: m_rready_o = 1.
  - On m_rvalid_i, capture RDATA and RRESP.
  - proto_err = (RID != TXN_ID) | ~RLAST.
  - Go to RSP.
- RSP: rsp_valid_o = 1, with registered outputs stable.
  - On rsp_ready_i, go to IDLE; cmd_ready_o = 1 in the following cycle.
  - Back-pressure is unbounded; the AXI side stays idle meanwhile.
- B/R signals arriving outside WR_RESP/RD_DATA are ignored; bready/rready are 0 there.
- Latency with a zero-wait slave: command accept at cycle 0, AW/W handshake at cycle 1, B at cycle 2, rsp_valid_o at cycle 3. The read path has the same timing.
- Throughput: at most 1 transaction per 4 cycles.
- rsp_resp_o passes xRESP through unchanged (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR).

Test Plan:
- Write addr 0x1000_0004, data 0xDEAD_BEEF, strb 4'hF, zero-wait slave -> AW/W valid at cycle 1 with AWSIZE 3'd2, AWLEN 0, WLAST 1; rsp_valid_o at cycle 3 with resp 00, proto_err 0.
- Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles with stable AWADDR; exactly one B accepted.
- Read 0x2000_0000, slave returns RDATA 0x1234_5678, RRESP 10, RLAST 1, RID 0 -> rsp_rdata_o = 0x1234_5678, rsp_resp_o = 10, proto_err 0.
- Read with RID = 5 (TXN_ID 0), RLAST 0 -> rsp_proto_err_o = 1, data still captured.
- rsp_ready_i held low 10 cycles -> rsp_valid_o and its outputs stable, cmd_ready_o = 0, new cmd_valid_i not accepted; accepted the cycle after the return to IDLE.
- reset_i asserted while WR_REQ waits on AWREADY -> AWVALID/WVALID drop asynchronously; after release cmd_ready_o = 1 and no rsp_valid_o is produced.
